// File: rtl/playback_sequencer.sv
// Replays a recorded take one step at a time from the record memory.
// Steps are STEP_TICKS long. Read data is sampled RD_LAT cycles into each step.
// The take either loops or ends in DONE. STEP_TICKS must exceed RD_LAT+1.
module playback_sequencer #(
  parameter int unsigned STEP_TICKS = 12500000,
  parameter int unsigned MAX_ADDR   = 128,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       play,
  input  logic       stop,
  input  logic       loop,
  input  logic       rec_done,
  input  logic       rec_q,
  output logic [7:0] checkadd,
  output logic       playing,
  output logic       note_out,
  output logic       step_strobe,
  output logic       finished
);

  localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(STEP_TICKS - 1);
  localparam logic [CW-1:0] READ_TICK = CW'(RD_LAT);
  localparam logic [7:0]    LAST_ADDR = 8'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    checkadd_q, checkadd_d;
  logic          play_dly_q, play_dly_d;
  logic          note_q, note_d;
  logic          strobe_q, strobe_d;
  logic          playing_q, playing_d;
  logic          finished_q, finished_d;
  logic          start;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    checkadd_d = checkadd_q;
    note_d     = note_q;
    strobe_d   = 1'b0;
    finished_d = finished_q;
    play_dly_d = play;
    start      = play & ~play_dly_q;

    // Losing rec_done mid-take means the recorder owns the memory port again.
    if (stop || (state_q == RUN && !rec_done)) begin
      state_d    = IDLE;
      cnt_d      = '0;
      checkadd_d = '0;
      note_d     = 1'b0;
      finished_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start && rec_done) begin
            state_d    = RUN;
            cnt_d      = '0;
            checkadd_d = '0;
            finished_d = 1'b0;
          end
        end
        RUN: begin
          cnt_d = (cnt_q == LAST_TICK) ? '0 : cnt_q + 1'b1;
          if (cnt_q == READ_TICK) begin
            note_d   = rec_q;
            strobe_d = rec_q;
          end
          if (cnt_q == LAST_TICK) begin
            if (checkadd_q < LAST_ADDR) begin
              checkadd_d = checkadd_q + 8'd1;
            end else if (loop) begin
              checkadd_d = '0;
            end else begin
              state_d    = DONE;
              note_d     = 1'b0;
              finished_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    playing_d = (state_d == RUN);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      checkadd_q <= '0;
      play_dly_q <= 1'b0;
      note_q     <= 1'b0;
      strobe_q   <= 1'b0;
      playing_q  <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      checkadd_q <= checkadd_d;
      play_dly_q <= play_dly_d;
      note_q     <= note_d;
      strobe_q   <= strobe_d;
      playing_q  <= playing_d;
      finished_q <= finished_d;
    end
  end

  assign checkadd    = checkadd_q;
  assign playing     = playing_q;
  assign note_out    = note_q;
  assign step_strobe = strobe_q;
  assign finished    = finished_q;

endmodule
